// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that maps NUM_CONSUMERS memory requesters onto NUM_CHANNELS memory channels.
// Latency: request to channel valid is 1 cycle; memory ready to consumer ready is 1 cycle.
// Backpressure: ungranted consumers hold valid; a channel waits for memory ready or times out.
module mem_rr_arbiter #(
  parameter int NUM_CONSUMERS  = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int WRITE_ENABLE   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           c_read_valid,
  input  logic [NUM_CONSUMERS-1:0]           c_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] c_read_address,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] c_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] c_write_data,
  output logic [NUM_CONSUMERS-1:0]           c_read_ready,
  output logic [NUM_CONSUMERS-1:0]           c_write_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] c_read_data,
  output logic [NUM_CHANNELS-1:0]            m_read_valid,
  output logic [NUM_CHANNELS-1:0]            m_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  m_read_address,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  m_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  m_write_data,
  input  logic [NUM_CHANNELS-1:0]            m_read_ready,
  input  logic [NUM_CHANNELS-1:0]            m_write_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  m_read_data,
  output logic                               timeout_err
);

  localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_t;

  // Per-element views of the flat buses
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] c_raddr, c_waddr;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_wdata;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_rdata;
  logic [NUM_CONSUMERS-1:0]                c_write_req;

  assign c_raddr = c_read_address;
  assign c_waddr = c_write_address;
  assign c_wdata = c_write_data;
  assign m_rdata = m_read_data;
  // With writes disabled a write request never makes a consumer eligible
  assign c_write_req = (WRITE_ENABLE != 0) ? c_write_valid : '0;

  state_t        state_q [NUM_CHANNELS];
  state_t        state_d [NUM_CHANNELS];
  logic [PW-1:0] owner_q [NUM_CHANNELS];
  logic [PW-1:0] owner_d [NUM_CHANNELS];
  logic [CW-1:0] cnt_q   [NUM_CHANNELS];
  logic [CW-1:0] cnt_d   [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0]                claim_q, claim_d, claim_clr;
  logic [PW-1:0]                           rr_ptr_q, rr_ptr_d;
  logic [NUM_CHANNELS-1:0]                 mrv_q, mrv_d, mwv_q, mwv_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_q, mra_d, mwa_q, mwa_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_q, mwd_d;
  logic [NUM_CONSUMERS-1:0]                crr_q, crr_d, cwr_q, cwr_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_q, crd_d;
  logic                                    terr_q, terr_d;

  logic          found, granted;
  logic [PW-1:0] sel, cand, last;
  int            idx;

  // Next-state: channels arbitrate in ascending order; claims taken by lower channels are seen by higher ones
  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      owner_d[ch] = owner_q[ch];
      cnt_d[ch]   = cnt_q[ch];
    end
    claim_d   = claim_q;
    claim_clr = '0;
    rr_ptr_d  = rr_ptr_q;
    mrv_d     = mrv_q;
    mwv_d     = mwv_q;
    mra_d     = mra_q;
    mwa_d     = mwa_q;
    mwd_d     = mwd_q;
    crr_d     = crr_q;
    cwr_d     = cwr_q;
    crd_d     = crd_q;
    terr_d    = terr_q;
    found     = 1'b0;
    granted   = 1'b0;
    sel       = '0;
    cand      = '0;
    last      = rr_ptr_q;
    idx       = 0;

    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          sel   = '0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            cand = PW'(idx);
            if (!found && (c_read_valid[cand] || c_write_req[cand]) && !claim_d[cand]) begin
              found = 1'b1;
              sel   = cand;
            end
          end
          if (found) begin
            claim_d[sel] = 1'b1;
            owner_d[ch]  = sel;
            cnt_d[ch]    = '0;
            last         = sel;
            granted      = 1'b1;
            // Read wins when a consumer asks for both
            if (c_read_valid[sel]) begin
              state_d[ch] = READ_WAIT;
              mrv_d[ch]   = 1'b1;
              mra_d[ch]   = c_raddr[sel];
            end else begin
              state_d[ch] = WRITE_WAIT;
              mwv_d[ch]   = 1'b1;
              mwa_d[ch]   = c_waddr[sel];
              mwd_d[ch]   = c_wdata[sel];
            end
          end
        end
        READ_WAIT: begin
          // Ready on the final counted cycle still counts as success
          if (m_read_ready[ch]) begin
            mrv_d[ch]           = 1'b0;
            crr_d[owner_q[ch]]  = 1'b1;
            crd_d[owner_q[ch]]  = m_rdata[ch];
            state_d[ch]         = READ_RELAY;
          end else if (cnt_q[ch] == CW'(TIMEOUT_CYCLES - 1)) begin
            mrv_d[ch]           = 1'b0;
            crr_d[owner_q[ch]]  = 1'b1;
            crd_d[owner_q[ch]]  = '0;
            terr_d              = 1'b1;
            state_d[ch]         = READ_RELAY;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CW'(1);
          end
        end
        WRITE_WAIT: begin
          if (m_write_ready[ch]) begin
            mwv_d[ch]           = 1'b0;
            cwr_d[owner_q[ch]]  = 1'b1;
            state_d[ch]         = WRITE_RELAY;
          end else if (cnt_q[ch] == CW'(TIMEOUT_CYCLES - 1)) begin
            mwv_d[ch]           = 1'b0;
            cwr_d[owner_q[ch]]  = 1'b1;
            terr_d              = 1'b1;
            state_d[ch]         = WRITE_RELAY;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CW'(1);
          end
        end
        READ_RELAY: begin
          if (!c_read_valid[owner_q[ch]]) begin
            crr_d[owner_q[ch]]     = 1'b0;
            claim_clr[owner_q[ch]] = 1'b1;
            state_d[ch]            = IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!c_write_valid[owner_q[ch]]) begin
            cwr_d[owner_q[ch]]     = 1'b0;
            claim_clr[owner_q[ch]] = 1'b1;
            state_d[ch]            = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end

    // Released claims take effect next cycle so a consumer is not re-granted in its exit cycle
    claim_d = claim_d & ~claim_clr;
    if (granted) rr_ptr_d = (last == PW'(NUM_CONSUMERS - 1)) ? '0 : last + PW'(1);
  end

  // State register; reset abandons any in-flight request without completing it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
        cnt_q[ch]   <= '0;
      end
      claim_q  <= '0;
      rr_ptr_q <= '0;
      mrv_q    <= '0;
      mwv_q    <= '0;
      mra_q    <= '0;
      mwa_q    <= '0;
      mwd_q    <= '0;
      crr_q    <= '0;
      cwr_q    <= '0;
      crd_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      claim_q  <= claim_d;
      rr_ptr_q <= rr_ptr_d;
      mrv_q    <= mrv_d;
      mwv_q    <= mwv_d;
      mra_q    <= mra_d;
      mwa_q    <= mwa_d;
      mwd_q    <= mwd_d;
      crr_q    <= crr_d;
      cwr_q    <= cwr_d;
      crd_q    <= crd_d;
      terr_q   <= terr_d;
    end
  end

  assign m_read_valid    = mrv_q;
  assign m_write_valid   = mwv_q;
  assign m_read_address  = mra_q;
  assign m_write_address = mwa_q;
  assign m_write_data    = mwd_q;
  assign c_read_ready    = crr_q;
  assign c_write_ready   = cwr_q;
  assign c_read_data     = crd_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: one write-enabled instance and one with writes disabled.
// Both share inputs; expected values are hand-computed per scenario.
module tb_mem_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  c_read_valid, c_write_valid;
  logic [31:0] c_read_address, c_write_address;
  logic [63:0] c_write_data;
  logic [1:0]  m_read_ready, m_write_ready;
  logic [31:0] m_read_data;

  logic [3:0]  c_read_ready, c_write_ready;
  logic [63:0] c_read_data;
  logic [1:0]  m_read_valid, m_write_valid;
  logic [15:0] m_read_address, m_write_address;
  logic [31:0] m_write_data;
  logic        timeout_err;

  logic [3:0]  nw_c_read_ready, nw_c_write_ready;
  logic [63:0] nw_c_read_data;
  logic [1:0]  nw_m_read_valid, nw_m_write_valid;
  logic [15:0] nw_m_read_address, nw_m_write_address;
  logic [31:0] nw_m_write_data;
  logic        nw_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(16),
                   .WRITE_ENABLE(1), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset),
    .c_read_valid(c_read_valid), .c_write_valid(c_write_valid),
    .c_read_address(c_read_address), .c_write_address(c_write_address),
    .c_write_data(c_write_data),
    .c_read_ready(c_read_ready), .c_write_ready(c_write_ready), .c_read_data(c_read_data),
    .m_read_valid(m_read_valid), .m_write_valid(m_write_valid),
    .m_read_address(m_read_address), .m_write_address(m_write_address),
    .m_write_data(m_write_data),
    .m_read_ready(m_read_ready), .m_write_ready(m_write_ready), .m_read_data(m_read_data),
    .timeout_err(timeout_err)
  );

  mem_rr_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(16),
                   .WRITE_ENABLE(0), .TIMEOUT_CYCLES(8)) u_dut_nw (
    .clk(clk), .reset(reset),
    .c_read_valid(c_read_valid), .c_write_valid(c_write_valid),
    .c_read_address(c_read_address), .c_write_address(c_write_address),
    .c_write_data(c_write_data),
    .c_read_ready(nw_c_read_ready), .c_write_ready(nw_c_write_ready), .c_read_data(nw_c_read_data),
    .m_read_valid(nw_m_read_valid), .m_write_valid(nw_m_write_valid),
    .m_read_address(nw_m_read_address), .m_write_address(nw_m_write_address),
    .m_write_data(nw_m_write_data),
    .m_read_ready(m_read_ready), .m_write_ready(m_write_ready), .m_read_data(m_read_data),
    .timeout_err(nw_timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    c_read_valid = '0; c_write_valid = '0;
    c_read_address = '0; c_write_address = '0; c_write_data = '0;
    m_read_ready = '0; m_write_ready = '0; m_read_data = '0;
    tick(); tick();
    check("rst_mrv", 64'(m_read_valid), 64'h0);
    check("rst_mwv", 64'(m_write_valid), 64'h0);
    check("rst_crr", 64'(c_read_ready), 64'h0);
    check("rst_cwr", 64'(c_write_ready), 64'h0);
    check("rst_crd", c_read_data, 64'h0);
    check("rst_terr", 64'(timeout_err), 64'h0);
    reset = 1'b0;

    // Single read, consumer 2, memory answers in the third wait cycle
    c_read_address[23:16] = 8'h3C;
    c_read_valid = 4'b0100;
    tick();
    check("t1_mrv", 64'(m_read_valid), 64'h1);
    check("t1_mra", 64'(m_read_address), 64'h003C);
    tick(); tick();
    check("t1_crr_wait", 64'(c_read_ready), 64'h0);
    m_read_ready = 2'b01; m_read_data = 32'h0000_BEEF;
    tick();
    check("t1_crr", 64'(c_read_ready), 64'h4);
    check("t1_crd", 64'(c_read_data[47:32]), 64'hBEEF);
    check("t1_mrv_drop", 64'(m_read_valid), 64'h0);
    m_read_ready = '0; c_read_valid = '0;
    tick();
    check("t1_crr_exit", 64'(c_read_ready), 64'h0);

    reset = 1'b1; tick(); reset = 1'b0;

    // All four consumers read at once over two channels
    c_read_address = 32'h1312_1110;
    c_read_valid = 4'b1111;
    tick();
    check("t2_mrv_a", 64'(m_read_valid), 64'h3);
    check("t2_mra_a", 64'(m_read_address), 64'h1110);
    m_read_ready = 2'b11; m_read_data = 32'hA001_A000;
    tick();
    check("t2_crr_a", 64'(c_read_ready), 64'h3);
    check("t2_crd_a", 64'(c_read_data[31:0]), 64'hA001_A000);
    m_read_ready = '0; c_read_valid = 4'b1100;
    tick();
    check("t2_crr_exit_a", 64'(c_read_ready), 64'h0);
    check("t2_mrv_idle", 64'(m_read_valid), 64'h0);
    tick();
    check("t2_mrv_b", 64'(m_read_valid), 64'h3);
    check("t2_mra_b", 64'(m_read_address), 64'h1312);
    m_read_ready = 2'b11; m_read_data = 32'hA003_A002;
    tick();
    check("t2_crr_b", 64'(c_read_ready), 64'hC);
    check("t2_crd_b", 64'(c_read_data[63:32]), 64'hA003_A002);
    m_read_ready = '0; c_read_valid = '0;
    tick();
    check("t2_crr_exit_b", 64'(c_read_ready), 64'h0);
    tick();
    check("t2_no_reserve", 64'(m_read_valid), 64'h0);

    // Consumer 1 asks for read and write together; read goes first
    c_read_address[15:8] = 8'h21; c_write_address[15:8] = 8'h31; c_write_data[31:16] = 16'h1234;
    c_read_valid = 4'b0010; c_write_valid = 4'b0010;
    tick();
    check("t3_mrv", 64'(m_read_valid), 64'h1);
    check("t3_mwv_none", 64'(m_write_valid), 64'h0);
    check("t3_mra", 64'(m_read_address[7:0]), 64'h21);
    m_read_ready = 2'b01; m_read_data = 32'h0000_7777;
    tick();
    check("t3_crr", 64'(c_read_ready), 64'h2);
    check("t3_cwr_none", 64'(c_write_ready), 64'h0);
    m_read_ready = '0;
    tick();
    check("t3_mwv_relay", 64'(m_write_valid), 64'h0);
    c_read_valid = '0;
    tick();
    check("t3_crr_exit", 64'(c_read_ready), 64'h0);
    check("t3_mwv_exit", 64'(m_write_valid), 64'h0);
    tick();
    check("t3_mwv", 64'(m_write_valid), 64'h1);
    check("t3_mwa", 64'(m_write_address[7:0]), 64'h31);
    check("t3_mwd", 64'(m_write_data[15:0]), 64'h1234);
    m_write_ready = 2'b01;
    tick();
    check("t3_cwr", 64'(c_write_ready), 64'h2);
    check("t3_mwv_drop", 64'(m_write_valid), 64'h0);
    m_write_ready = '0; c_write_valid = '0;
    tick();
    check("t3_cwr_exit", 64'(c_write_ready), 64'h0);

    // Ready on the last counted wait cycle is a success, not a timeout
    c_read_address[31:24] = 8'h44;
    c_read_valid = 4'b1000;
    tick();
    check("t4_mra", 64'(m_read_address[7:0]), 64'h44);
    repeat (7) tick();
    check("t4_mrv_hold", 64'(m_read_valid), 64'h1);
    check("t4_crr_wait", 64'(c_read_ready), 64'h0);
    m_read_ready = 2'b01; m_read_data = 32'h0000_5A5A;
    tick();
    check("t4_crr", 64'(c_read_ready), 64'h8);
    check("t4_crd", 64'(c_read_data[63:48]), 64'h5A5A);
    check("t4_terr", 64'(timeout_err), 64'h0);
    m_read_ready = '0; c_read_valid = '0;
    tick();

    // Memory never answers: timeout after 8 wait cycles
    c_read_valid = 4'b0001;
    tick();
    repeat (7) tick();
    check("t5_crr_wait", 64'(c_read_ready), 64'h0);
    check("t5_terr_wait", 64'(timeout_err), 64'h0);
    check("t5_mrv_wait", 64'(m_read_valid), 64'h1);
    tick();
    check("t5_crr", 64'(c_read_ready), 64'h1);
    check("t5_crd", 64'(c_read_data[15:0]), 64'h0);
    check("t5_terr", 64'(timeout_err), 64'h1);
    check("t5_mrv_drop", 64'(m_read_valid), 64'h0);
    c_read_valid = '0;
    tick();
    check("t5_crr_exit", 64'(c_read_ready), 64'h0);
    repeat (3) tick();
    check("t5_terr_sticky", 64'(timeout_err), 64'h1);

    // Reset in the middle of a read wait
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_terr_clr", 64'(timeout_err), 64'h0);
    c_read_valid = 4'b0100;
    tick();
    check("t6_mrv", 64'(m_read_valid), 64'h1);
    reset = 1'b1; m_read_ready = 2'b01; m_read_data = 32'h0000_BEEF;
    tick();
    check("t6_rst_mrv", 64'(m_read_valid), 64'h0);
    check("t6_rst_crr", 64'(c_read_ready), 64'h0);
    check("t6_rst_crd", c_read_data, 64'h0);
    reset = 1'b0; m_read_ready = '0;
    tick();
    check("t6_crr_nopulse", 64'(c_read_ready), 64'h0);
    check("t6_regrant", 64'(m_read_valid), 64'h1);
    check("t6_mra", 64'(m_read_address[7:0]), 64'h12);
    m_read_ready = 2'b01; m_read_data = 32'h0000_600D;
    tick();
    check("t6_crr", 64'(c_read_ready), 64'h4);
    check("t6_crd", 64'(c_read_data[47:32]), 64'h600D);
    m_read_ready = '0; c_read_valid = '0;
    tick();

    // Writes disabled: the second instance never issues or completes a write
    c_write_address[7:0] = 8'h55; c_write_data[15:0] = 16'hCAFE;
    c_write_valid = 4'b0001;
    tick();
    check("t7_main_mwv", 64'(m_write_valid), 64'h1);
    check("t7_nw_mwv_0", 64'(nw_m_write_valid), 64'h0);
    check("t7_nw_cwr_0", 64'(nw_c_write_ready), 64'h0);
    for (int i = 1; i < 20; i++) begin
      tick();
      check("t7_nw_mwv", 64'(nw_m_write_valid), 64'h0);
      check("t7_nw_cwr", 64'(nw_c_write_ready), 64'h0);
    end
    c_write_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of requesting fetchers/LSUs.
REQ-002 SHALL have parameter NUM_CHANNELS, default 2, number of concurrent memory channels.
REQ-003 SHALL have parameter ADDR_BITS, default 8, address width.
REQ-004 SHALL have parameter DATA_BITS, default 16, data width.
REQ-005 SHALL have parameter WRITE_ENABLE, default 1; 0 means writes are never granted.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, max wait cycles per memory request.
REQ-007 clk  input  1  clock, all state on rising edge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 c_read_valid / c_write_valid  input  NUM_CONSUMERS  per-consumer request flags.
REQ-010 c_read_address / c_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed, consumer j at slice j.
REQ-011 c_write_data  input  NUM_CONSUMERS*DATA_BITS  write payload.
REQ-012 c_read_ready / c_write_ready  output  NUM_CONSUMERS  completion flags.
REQ-013 c_read_data  output  NUM_CONSUMERS*DATA_BITS  returned read data.
REQ-014 m_read_valid / m_write_valid  output  NUM_CHANNELS  channel request flags.
REQ-015 m_read_address / m_write_address  output  NUM_CHANNELS*ADDR_BITS; m_write_data  output  NUM_CHANNELS*DATA_BITS.
REQ-016 m_read_ready / m_write_ready  input  NUM_CHANNELS; m_read_data  input  NUM_CHANNELS*DATA_BITS.
REQ-017 timeout_err  output  1  sticky; set on any channel timeout, cleared only by reset.

Function
REQ-018 Each channel SHALL run FSM IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
REQ-019 Eligible consumer: valid high and claim bit clear; claim set at grant, cleared on relay exit.
REQ-020 Single round-robin pointer rr_ptr (0..NUM_CONSUMERS-1); each IDLE channel, in ascending channel index, SHALL grant first eligible consumer searching rr_ptr, rr_ptr+1, ... modulo NUM_CONSUMERS.
REQ-021 Claims by lower channels SHALL be visible to higher channels in the same cycle; no consumer served by two channels.
REQ-022 After any grant cycle rr_ptr SHALL become (last consumer granted that cycle + 1) mod NUM_CONSUMERS; unchanged if no grant.
REQ-023 If one consumer asserts read and write valid together, read SHALL win; write waits for a later grant.
REQ-024 Grant at edge k: m_*_valid, address (and write data) SHALL be driven from edge k, held stable until ready.
REQ-025 WAIT: on m_*_ready high, SHALL drop m_*_valid, assert c_*_ready (capture m_read_data into c_read_data for reads) next edge, enter RELAY.
REQ-026 RELAY: when consumer's matching valid is low, SHALL deassert c_*_ready, clear claim, return IDLE; consumer re-grantable no earlier than the following cycle.
REQ-027 Per-channel wait counter SHALL reset to 0 on grant and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without ready, SHALL drop m_*_valid, return c_read_data=0 with c_*_ready, set timeout_err, enter RELAY.
REQ-028 Ready arriving in the same cycle the counter hits TIMEOUT_CYCLES SHALL be treated as success (no error).
REQ-029 WRITE_ENABLE=0: write requests never granted, m_write_valid and c_write_ready constant 0.
REQ-030 Consumer deasserting valid during WAIT SHALL not abort the memory transaction; completion proceeds and relay exits next cycle.
REQ-031 More eligible consumers than IDLE channels: ungranted consumers SHALL hold and be served by round-robin order, starvation-free.

Reset
REQ-032 On reset all outputs SHALL be 0, all channels IDLE, claims clear, rr_ptr=0, counters 0, timeout_err=0.
REQ-033 Reset mid-transaction SHALL abandon in-flight requests without issuing c_*_ready.

Verification
REQ-034 Single read, consumer 2, addr 0x3C, memory returns 0xBEEF after 3 cycles -> m_read_valid[0] one cycle after request, c_read_ready[2]=1 with data 0xBEEF one cycle after m_read_ready.
REQ-035 All 4 consumers read simultaneously, 2 channels -> consumers 0,1 granted first, rr_ptr=2, then 2,3; each consumer served exactly once.
REQ-036 Consumer 1 holds read and write valid -> read granted first; write granted only after read relay exits.
REQ-037 Memory never asserts ready, TIMEOUT_CYCLES=8 -> after 8 WAIT cycles c_read_ready=1, data 0, timeout_err=1 and stays 1.
REQ-038 Reset asserted during READ_WAIT -> next cycle all outputs 0, no c_read_ready pulse; new request after reset served normally.
REQ-039 WRITE_ENABLE=0, consumer 0 write valid for 20 cycles -> m_write_valid and c_write_ready remain 0 throughout.
